// File: rtl/altair_pkg.sv
// Shared types and widths for the Altair front-panel controller and its RAM.
package altair_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    EXAM      = 3'd1,
    EXAM_NEXT = 3'd2,
    DEP       = 3'd3,
    DEP_NEXT  = 3'd4
  } cmd_e;

  // Fixed priority: exam > exam_next > dep > dep_next; losers are dropped.
  function automatic cmd_e pick_cmd(input logic exam, input logic exam_next,
                                    input logic dep, input logic dep_next);
    cmd_e c;
    c = NONE;
    if (exam)           c = EXAM;
    else if (exam_next) c = EXAM_NEXT;
    else if (dep)       c = DEP;
    else if (dep_next)  c = DEP_NEXT;
    return c;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// One-flop rising-edge detector. The history flop resets to 1 so a button
// already held when reset releases does not produce a spurious edge.
module btn_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic rise_o
);

  logic prev_q;

  // Track the previous button level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_q <= 1'b1;
    else          prev_q <= btn_i;
  end

  assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/front_panel_ctrl.sv
// Altair front-panel controller: owns the RAM port while stopped, running
// examine/deposit sequences and driving the LEDs; passes the CPU bus through
// to the RAM while running and idle.
//
// state | meaning
// IDLE  | waiting for a panel command, or CPU owns the bus when run=1
// WR    | one-cycle RAM write of data_sw at addr_led
// RD    | RAM read strobe at addr_led
// CAP   | capture RAM read data into data_led
module front_panel_ctrl #(
  parameter int ADDR_WIDTH = altair_pkg::ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             run,
  input  logic [ADDR_WIDTH-1:0]            addr_sw,
  input  logic [altair_pkg::DATA_WIDTH-1:0] data_sw,
  input  logic                             btn_exam,
  input  logic                             btn_exam_next,
  input  logic                             btn_dep,
  input  logic                             btn_dep_next,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [altair_pkg::DATA_WIDTH-1:0] cpu_dout,
  input  logic                             cpu_rd,
  input  logic                             cpu_we,
  output logic                             cpu_wait,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [altair_pkg::DATA_WIDTH-1:0] mem_din,
  output logic                             mem_rd,
  output logic                             mem_we,
  input  logic [altair_pkg::DATA_WIDTH-1:0] mem_dout,
  output logic [ADDR_WIDTH-1:0]            addr_led,
  output logic [altair_pkg::DATA_WIDTH-1:0] data_led,
  output logic                             busy
);

  import altair_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_led_q, addr_led_d;
  logic [DATA_WIDTH-1:0]   data_led_q, data_led_d;
  logic                    exam_rise, exam_next_rise, dep_rise, dep_next_rise;
  logic                    cpu_grant;
  cmd_e                    cmd;

  btn_edge u_edge_exam      (.clk(clk), .reset_n(reset_n), .btn_i(btn_exam),      .rise_o(exam_rise));
  btn_edge u_edge_exam_next (.clk(clk), .reset_n(reset_n), .btn_i(btn_exam_next), .rise_o(exam_next_rise));
  btn_edge u_edge_dep       (.clk(clk), .reset_n(reset_n), .btn_i(btn_dep),       .rise_o(dep_rise));
  btn_edge u_edge_dep_next  (.clk(clk), .reset_n(reset_n), .btn_i(btn_dep_next),  .rise_o(dep_next_rise));

  // Commands are only taken when idle and stopped; edges at other times are lost.
  always_comb begin
    cmd = NONE;
    if (state_q == IDLE && !run)
      cmd = pick_cmd(exam_rise, exam_next_rise, dep_rise, dep_next_rise);
  end

  // Next-state and LED register update logic.
  always_comb begin
    state_d    = state_q;
    addr_led_d = addr_led_q;
    data_led_d = data_led_q;
    unique case (state_q)
      IDLE: begin
        unique case (cmd)
          EXAM: begin
            addr_led_d = addr_sw;
            state_d    = RD;
          end
          EXAM_NEXT: begin
            addr_led_d = addr_led_q + ADDR_ONE;
            state_d    = RD;
          end
          DEP: begin
            state_d = WR;
          end
          DEP_NEXT: begin
            addr_led_d = addr_led_q + ADDR_ONE;
            state_d    = WR;
          end
          default: ;
        endcase
      end
      WR:  state_d = RD;
      RD:  state_d = CAP;
      CAP: begin
        data_led_d = mem_dout;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and LED registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_led_q <= '0;
      data_led_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_led_q <= addr_led_d;
      data_led_q <= data_led_d;
    end
  end

  // RAM port mux: CPU only gets the bus on IDLE cycles with run high, so a
  // run request during a panel op waits for the op to finish.
  always_comb begin
    cpu_grant = run && (state_q == IDLE);
    mem_addr  = addr_led_q;
    mem_din   = data_sw;
    mem_rd    = (state_q == RD);
    mem_we    = (state_q == WR);
    if (cpu_grant) begin
      mem_addr = cpu_addr;
      mem_din  = cpu_dout;
      mem_rd   = cpu_rd;
      mem_we   = cpu_we;
    end
  end

  assign cpu_wait = ~cpu_grant;
  assign busy     = (state_q != IDLE);
  assign addr_led = addr_led_q;
  assign data_led = data_led_q;

endmodule

// File: doc/front_panel_ctrl.md
# front_panel_ctrl

Altair front-panel controller between the panel switches/CPU bus and the 256×8 `ram_memory` block. It owns the RAM port while the machine is stopped, executing EXAMINE, EXAMINE NEXT, DEPOSIT and DEPOSIT NEXT as short read/write sequences, and driving the address/data LEDs. While running, it passes the CPU bus straight through to the RAM.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: RAM address width; must match `ram_memory`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  1 = CPU owns RAM, 0 = panel owns RAM.
- `addr_sw`  in  8  address switches.
- `data_sw`  in  8  data switches.
- `btn_exam`, `btn_exam_next`, `btn_dep`, `btn_dep_next`  in  1 each  debounced panel buttons, level.
- `cpu_addr`  in  8  CPU address.
- `cpu_dout`  in  8  CPU write data.
- `cpu_rd`, `cpu_we`  in  1 each  CPU strobes.
- `cpu_wait`  out  1  high while the panel owns the bus or a panel op is in flight.
- `mem_addr`  out  8  to RAM `addr`.
- `mem_din`  out  8  to RAM `data_in`.
- `mem_rd`, `mem_we`  out  1 each  to RAM `rd`/`we`.
- `mem_dout`  in  8  from RAM `data_out`; valid one cycle after `mem_rd`.
- `addr_led`, `data_led`  out  8 each  panel LEDs.
- `busy`  out  1  panel FSM not in IDLE.

## Operation
- Buttons are rising-edge detected internally. Edge registers reset to 1, so a button held through reset release does not fire.
- Commands are accepted only in IDLE with `run`=0.
- Simultaneous edges resolve by priority: exam > exam_next > dep > dep_next. Lower-priority edges in that cycle are dropped.
- Edges arriving while `busy`=1 are dropped.
- FSM states: IDLE, RD, CAP, WR.
  - EXAMINE: `addr_led`←`addr_sw`, then RD.
  - EXAMINE NEXT: `addr_led`←`addr_led`+1 (mod 256, 0xFF→0x00), then RD.
  - DEPOSIT: WR at `addr_led` with `data_sw`.
  - DEPOSIT NEXT: `addr_led`←`addr_led`+1 (wraps), then WR.
  - WR: `mem_we`=1, `mem_addr`=`addr_led`, `mem_din`=`data_sw` for one cycle; next state RD (readback).
  - RD: `mem_rd`=1, `mem_addr`=`addr_led`; next state CAP.
  - CAP: `data_led`←`mem_dout`; next state IDLE.
- `run`=1 in IDLE: mux selects the CPU. `mem_addr`/`mem_din`/`mem_rd`/`mem_we` = `cpu_*` combinationally. `cpu_wait`=0, LEDs hold.
- `run` rising while `busy`: the panel op completes and the CPU is granted on the first IDLE cycle. `cpu_wait`=1 until then.
- `run` falling while the CPU is mid-access: the panel takes the bus next cycle. The CPU must not rely on an access issued in that cycle.
- Panel-mode outputs when idle: `mem_rd`=`mem_we`=0, `mem_addr`=`addr_led`, `mem_din`=`data_sw`.

## Timing
- Reset values: state IDLE, `addr_led`=0x00, `data_led`=0x00, `busy`=0, panel-side `mem_rd`=`mem_we`=0. `cpu_wait`=~`run`.
- Reset mid-op aborts immediately; no partial write beyond the cycle already clocked.
- EXAMINE / EXAMINE NEXT:
  - Edge sampled at cycle 0.
  - RD in cycle 1.
  - CAP in cycle 2; `data_led` updates at the end of cycle 2.
  - IDLE in cycle 3; new command accepted in cycle 3.
- DEPOSIT / DEPOSIT NEXT:
  - WR in cycle 1, RD in cycle 2, CAP in cycle 3.
  - `data_led` shows the written value from cycle 4.
- `addr_led` updates at the end of cycle 0 for all commands.
- `busy`=1 for cycles 1..2 (examine) or 1..3 (deposit).

## Structure
- `altair_pkg`:
  - FSM state enum (IDLE, RD, CAP, WR).
  - Command enum (NONE, EXAM, EXAM_NEXT, DEP, DEP_NEXT).
  - `ADDR_WIDTH` / `DATA_WIDTH` constants shared with `ram_memory`.
- Sub-module `btn_edge`: one-flop rising-edge detector with reset-to-1, instantiated four times.
- Top level holds the priority encoder, FSM, LED registers and the bus mux.

## Test plan
- Reset with `btn_exam` held; release reset → no command, `addr_led`=0x00, `busy`=0.
- RAM preloaded [0x10]=0xA5; `addr_sw`=0x10, pulse exam → `mem_rd` in cycle 1, `data_led`=0xA5 by cycle 3, `addr_led`=0x10.
- `addr_led`=0xFF, pulse dep_next with `data_sw`=0x3C → `addr_led`=0x00, write of 0x3C to address 0x00 in cycle 1, `data_led`=0x3C in cycle 4.
- exam and dep edges in the same cycle → only exam runs, no `mem_we`. Dep edge pulsed during `busy` → ignored.
- `run`=1, CPU writes 0x77 to 0x20 → RAM [0x20]=0x77, `cpu_wait`=0. Then `run`=0 and exam at 0x20 → `data_led`=0x77.
- `run` raised in cycle 2 of a deposit → write and readback complete, `cpu_wait` deasserts the first cycle after CAP.
